// File: rtl/iob2axi_pkg.sv
// Shared AXI4 field widths, fixed encodings and FSM state type for the IOb-to-AXI bridges.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iob2axi_pkg;

   // AXI4 field widths
   localparam int AXI_LEN_W   = 8;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_LOCK_W  = 1;
   localparam int AXI_CACHE_W = 4;
   localparam int AXI_PROT_W  = 3;
   localparam int AXI_QOS_W   = 4;
   localparam int AXI_RESP_W  = 2;
   localparam int AXI_ID_W    = 1;

   // Burst type encodings
   localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;

   // Cache / protection attributes driven on every burst
   localparam logic [AXI_CACHE_W-1:0] AXI_CACHE_MODIFIABLE = 4'b0010;
   localparam logic [AXI_PROT_W-1:0]  AXI_PROT_NONSECURE   = 3'b010;

   localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY = 2'b00;

   // Burst length in beats (1..256) needs one bit more than awlen
   localparam int BLEN_W = AXI_LEN_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_ADDR,
      ST_DATA,
      ST_RESP
   } state_t;

endpackage

// File: rtl/iob2axi_burst_len.sv
// Next burst length: min(remaining, MAX_BURST, beats left before the next 4 KB boundary).
// Latency: purely combinational.
// Backpressure: none; caller registers the result.
module iob2axi_burst_len
   import iob2axi_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int TLEN_W    = 16,
   parameter int MAX_BURST = 256
) (
   input  logic [11:0]       addr_lo,
   input  logic [TLEN_W-1:0] remaining,
   output logic [BLEN_W-1:0] blen
);
   localparam int SHIFT = $clog2(DATA_W / 8);
   localparam int CW    = (TLEN_W > 13) ? TLEN_W : 13;

   logic [12:0]   bytes_to_4k;
   logic [12:0]   beats_to_4k;
   logic [12:0]   cap;
   logic [CW-1:0] rem_w;
   logic [CW-1:0] cap_w;

   // Clamp to the 4 KB page first, then to MAX_BURST, then to what is left
   always_comb begin
      bytes_to_4k = 13'h1000 - {1'b0, addr_lo};
      beats_to_4k = bytes_to_4k >> SHIFT;
      cap         = (beats_to_4k < 13'(MAX_BURST)) ? beats_to_4k : 13'(MAX_BURST);
      rem_w       = CW'(remaining);
      cap_w       = CW'(cap);
      blen        = (rem_w < cap_w) ? BLEN_W'(rem_w) : BLEN_W'(cap);
   end

endmodule

// File: rtl/iob2axi_wr_split.sv
// Native-to-AXI4 write master: one command split into INCR bursts (<= MAX_BURST, never across 4 KB).
// Latency: start -> awvalid 2 cycles; bvalid -> done 1 cycle (last burst) or next awvalid 2 cycles.
// Backpressure: s_ready mirrors wready in DATA only; awaddr/awlen held until awready; one burst in flight.
module iob2axi_wr_split
   import iob2axi_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TLEN_W    = 16,
   parameter int MAX_BURST = 256
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      addr,
   input  logic [TLEN_W-1:0]      length,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   input  logic                   s_valid,
   input  logic [DATA_W-1:0]      s_wdata,
   input  logic [DATA_W/8-1:0]    s_wstrb,
   output logic                   s_ready,
   output logic [AXI_ID_W-1:0]    m_axi_awid,
   output logic [ADDR_W-1:0]      m_axi_awaddr,
   output logic [AXI_LEN_W-1:0]   m_axi_awlen,
   output logic [AXI_SIZE_W-1:0]  m_axi_awsize,
   output logic [AXI_BURST_W-1:0] m_axi_awburst,
   output logic [AXI_LOCK_W-1:0]  m_axi_awlock,
   output logic [AXI_CACHE_W-1:0] m_axi_awcache,
   output logic [AXI_PROT_W-1:0]  m_axi_awprot,
   output logic [AXI_QOS_W-1:0]   m_axi_awqos,
   output logic                   m_axi_awvalid,
   input  logic                   m_axi_awready,
   output logic [DATA_W-1:0]      m_axi_wdata,
   output logic [DATA_W/8-1:0]    m_axi_wstrb,
   output logic                   m_axi_wlast,
   output logic                   m_axi_wvalid,
   input  logic                   m_axi_wready,
   input  logic                   m_axi_bvalid,
   input  logic [AXI_RESP_W-1:0]  m_axi_bresp,
   output logic                   m_axi_bready
);
   localparam int SHIFT = $clog2(DATA_W / 8);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q;
   logic [TLEN_W-1:0]     rem_q;
   logic [BLEN_W-1:0]     blen_q;
   logic [BLEN_W-1:0]     cnt_q;
   logic [BLEN_W-1:0]     blen_calc;
   logic [AXI_LEN_W-1:0]  awlen_q;
   logic                  error_q;
   logic                  done_q;
   logic                  last_beat;
   logic                  beat_hs;
   logic [ADDR_W-1:0]     addr_next;
   logic [TLEN_W-1:0]     rem_next;

   iob2axi_burst_len #(
      .DATA_W    (DATA_W),
      .TLEN_W    (TLEN_W),
      .MAX_BURST (MAX_BURST)
   ) u_burst_len (
      .addr_lo   (addr_q[11:0]),
      .remaining (rem_q),
      .blen      (blen_calc)
   );

   assign last_beat = (cnt_q == blen_q - BLEN_W'(1));
   assign beat_hs   = s_valid & m_axi_wready;
   // Address arithmetic wraps silently at 2^ADDR_W
   assign addr_next = addr_q + (ADDR_W'(blen_q) << SHIFT);
   assign rem_next  = rem_q - TLEN_W'(blen_q);

   // Fixed AXI attributes and data pass-through
   assign m_axi_awid    = '0;
   assign m_axi_awsize  = AXI_SIZE_W'(SHIFT);
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awlock  = '0;
   assign m_axi_awcache = AXI_CACHE_MODIFIABLE;
   assign m_axi_awprot  = AXI_PROT_NONSECURE;
   assign m_axi_awqos   = '0;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = awlen_q;
   assign m_axi_wdata   = s_wdata;
   assign m_axi_wstrb   = s_wstrb;
   assign done          = done_q;
   assign error         = error_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state and per-state handshake outputs
   always_comb begin
      state_d       = state_q;
      busy          = 1'b1;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      s_ready       = 1'b0;
      m_axi_bready  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start && (length != '0)) state_d = ST_CALC;
         end
         ST_CALC: state_d = ST_ADDR;
         ST_ADDR: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) state_d = ST_DATA;
         end
         ST_DATA: begin
            m_axi_wvalid = s_valid;
            s_ready      = m_axi_wready;
            m_axi_wlast  = last_beat;
            if (beat_hs && last_beat) state_d = ST_RESP;
         end
         ST_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_d = (rem_next == '0) ? ST_IDLE : ST_CALC;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Transfer bookkeeping: address, remaining beats, burst length, beat count, status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         rem_q   <= '0;
         blen_q  <= '0;
         cnt_q   <= '0;
         awlen_q <= '0;
         error_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  error_q <= 1'b0;
                  if (length == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     addr_q <= addr;
                     rem_q  <= length;
                  end
               end
            end
            ST_CALC: begin
               blen_q  <= blen_calc;
               awlen_q <= AXI_LEN_W'(blen_calc - BLEN_W'(1));
               cnt_q   <= '0;
            end
            ST_DATA: begin
               if (beat_hs) cnt_q <= cnt_q + BLEN_W'(1);
            end
            ST_RESP: begin
               if (m_axi_bvalid) begin
                  error_q <= error_q | (m_axi_bresp != AXI_RESP_OKAY);
                  addr_q  <= addr_next;
                  rem_q   <= rem_next;
                  if (rem_next == '0) done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iob2axi_wr_split.sv
// Bench for iob2axi_wr_split: table of commands with hand-computed bursts, plus hand-timed sequences.
// Latency: checks start->awvalid, awready->wvalid, bvalid->done cycle relationships.
// Backpressure: responder can stall awready/wready/bvalid and the native source at random.
module tb_iob2axi_wr_split;
   import iob2axi_pkg::*;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int TLEN_W    = 16;
   localparam int MAX_BURST = 256;
   localparam int STRB_W    = DATA_W / 8;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start = 1'b0;
   logic [ADDR_W-1:0]      addr = '0;
   logic [TLEN_W-1:0]      length = '0;
   logic                   busy, done, error;
   logic                   s_valid = 1'b0;
   logic [DATA_W-1:0]      s_wdata = '0;
   logic [STRB_W-1:0]      s_wstrb = '0;
   logic                   s_ready;
   logic [AXI_ID_W-1:0]    m_axi_awid;
   logic [ADDR_W-1:0]      m_axi_awaddr;
   logic [AXI_LEN_W-1:0]   m_axi_awlen;
   logic [AXI_SIZE_W-1:0]  m_axi_awsize;
   logic [AXI_BURST_W-1:0] m_axi_awburst;
   logic [AXI_LOCK_W-1:0]  m_axi_awlock;
   logic [AXI_CACHE_W-1:0] m_axi_awcache;
   logic [AXI_PROT_W-1:0]  m_axi_awprot;
   logic [AXI_QOS_W-1:0]   m_axi_awqos;
   logic                   m_axi_awvalid;
   logic                   m_axi_awready = 1'b0;
   logic [DATA_W-1:0]      m_axi_wdata;
   logic [STRB_W-1:0]      m_axi_wstrb;
   logic                   m_axi_wlast;
   logic                   m_axi_wvalid;
   logic                   m_axi_wready = 1'b0;
   logic                   m_axi_bvalid = 1'b0;
   logic [AXI_RESP_W-1:0]  m_axi_bresp = '0;
   logic                   m_axi_bready;

   always #5 clk = ~clk;

   iob2axi_wr_split #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TLEN_W(TLEN_W), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .length(length),
      .busy(busy), .done(done), .error(error),
      .s_valid(s_valid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [ADDR_W-1:0] addr;
      int                len;
      bit                stall;
      int                bad;      // burst index answered with SLVERR, -1 for none
      int                nb;
      logic [ADDR_W-1:0] ea[4];
      int                el[4];
      bit                err;
   } vec_t;

   vec_t vecs[9];

   // Responder / source model state
   bit   manual = 1'b1;
   bit   stall = 1'b0;
   int   src_len = 0, src_idx = 0;
   logic [7:0] tag = 8'h00;
   logic [ADDR_W-1:0] aw_addr_q[$];
   logic [AXI_LEN_W-1:0] aw_len_q[$];
   logic [DATA_W+STRB_W:0] beat_q[$];
   int   pending_b = 0, b_count = 0, bad_burst = -1, done_seen = 0;
   bit   beat_taken = 1'b0, b_taken = 1'b0, aw_wait = 1'b0;
   logic [ADDR_W-1:0] aw_hold = '0;

   function automatic logic [DATA_W-1:0] mkdata(input int i);
      return {tag, 8'h5A, 16'(i)};
   endfunction

   function automatic logic [STRB_W-1:0] mkstrb(input int i);
      return STRB_W'(i * 5 + 3);
   endfunction

   // AXI slave + native source: drive at negedge, observe the upcoming handshake 1 unit later
   initial forever begin
      @(negedge clk);
      if (!manual) begin
         if (beat_taken) src_idx++;
         if (!(s_valid && !beat_taken))
            s_valid = (src_idx < src_len) && (!stall || $urandom_range(0, 2) != 0);
         s_wdata = mkdata(src_idx);
         s_wstrb = mkstrb(src_idx);
         m_axi_awready = !stall || $urandom_range(0, 1) != 0;
         m_axi_wready  = !stall || $urandom_range(0, 2) != 0;
         if (!(m_axi_bvalid && !b_taken)) begin
            if (pending_b > 0 && (!stall || $urandom_range(0, 1) != 0)) begin
               m_axi_bvalid = 1'b1;
               m_axi_bresp  = (b_count == bad_burst) ? 2'b10 : 2'b00;
            end else begin
               m_axi_bvalid = 1'b0;
               m_axi_bresp  = 2'b00;
            end
         end
         #1;
         beat_taken = s_valid && s_ready;
         if (m_axi_wvalid && m_axi_wready) begin
            beat_q.push_back({m_axi_wlast, m_axi_wstrb, m_axi_wdata});
            if (m_axi_wlast) pending_b++;
         end
         b_taken = m_axi_bvalid && m_axi_bready;
         if (b_taken) begin
            pending_b--;
            b_count++;
         end
         if (m_axi_awvalid) begin
            if (aw_wait) chk("awaddr_stable", m_axi_awaddr, aw_hold);
            if (m_axi_awready) begin
               aw_addr_q.push_back(m_axi_awaddr);
               aw_len_q.push_back(m_axi_awlen);
               aw_wait = 1'b0;
            end else begin
               aw_wait = 1'b1;
               aw_hold = m_axi_awaddr;
            end
         end else begin
            aw_wait = 1'b0;
         end
         if (done) done_seen++;
      end
   end

   task automatic flush();
      aw_addr_q.delete();
      aw_len_q.delete();
      beat_q.delete();
      pending_b = 0; b_count = 0; done_seen = 0; src_idx = 0; src_len = 0;
      beat_taken = 1'b0; b_taken = 1'b0; aw_wait = 1'b0;
      s_valid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
   endtask

   task automatic run_vec(input vec_t t, input int id);
      int next_end;
      int bi;
      logic [DATA_W+STRB_W:0] exp_beat;
      flush();
      tag       = 8'(id + 1);
      src_len   = t.len;
      stall     = t.stall;
      bad_burst = t.bad;
      addr      = t.addr;
      length    = TLEN_W'(t.len);
      manual    = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #2;
      chk("err_clear_on_start", error, 0);
      for (int c = 0; c < 5000 && done_seen == 0; c++) begin
         @(negedge clk);
         #2;
      end
      repeat (3) @(negedge clk);
      #2;
      chk("done_pulses", done_seen, 1);
      chk("busy_after_done", busy, 0);
      chk("error_at_done", error, t.err);
      chk("aw_count", aw_addr_q.size(), t.nb);
      for (int b = 0; b < t.nb; b++) begin
         if (b < aw_addr_q.size()) begin
            chk("awaddr", aw_addr_q[b], t.ea[b]);
            chk("awlen", aw_len_q[b], t.el[b]);
         end
      end
      chk("beat_count", beat_q.size(), t.len);
      next_end = t.el[0];
      bi = 0;
      for (int i = 0; i < t.len; i++) begin
         exp_beat = {(i == next_end), mkstrb(i), mkdata(i)};
         if (i == next_end) begin
            bi++;
            if (bi < t.nb) next_end += t.el[bi] + 1;
         end
         if (i < beat_q.size()) chk("beat_last_strb_data", beat_q[i], exp_beat);
      end
      manual = 1'b1;
      flush();
   endtask

   task automatic chk_reset_outputs(input string tagname);
      chk({tagname, "_busy"}, busy, 0);
      chk({tagname, "_done"}, done, 0);
      chk({tagname, "_error"}, error, 0);
      chk({tagname, "_awvalid"}, m_axi_awvalid, 0);
      chk({tagname, "_wvalid"}, m_axi_wvalid, 0);
      chk({tagname, "_wlast"}, m_axi_wlast, 0);
      chk({tagname, "_bready"}, m_axi_bready, 0);
      chk({tagname, "_s_ready"}, s_ready, 0);
      chk({tagname, "_awaddr"}, m_axi_awaddr, 0);
      chk({tagname, "_awlen"}, m_axi_awlen, 0);
   endtask

   vec_t post_rst;

   initial begin
      vecs[0] = '{32'h0000_0000, 4,   1'b0, -1, 1, '{32'h0, 32'h0, 32'h0, 32'h0}, '{3, 0, 0, 0}, 1'b0};
      vecs[1] = '{32'h0000_0000, 600, 1'b0, -1, 3, '{32'h0, 32'h400, 32'h800, 32'h0}, '{255, 255, 87, 0}, 1'b0};
      vecs[2] = '{32'h0000_0FF8, 8,   1'b0, -1, 2, '{32'hFF8, 32'h1000, 32'h0, 32'h0}, '{1, 5, 0, 0}, 1'b0};
      vecs[3] = '{32'h0000_0100, 37,  1'b1, -1, 1, '{32'h100, 32'h0, 32'h0, 32'h0}, '{36, 0, 0, 0}, 1'b0};
      vecs[4] = '{32'h0000_0000, 600, 1'b0, 1,  3, '{32'h0, 32'h400, 32'h800, 32'h0}, '{255, 255, 87, 0}, 1'b1};
      vecs[5] = '{32'h0000_2000, 10,  1'b0, -1, 1, '{32'h2000, 32'h0, 32'h0, 32'h0}, '{9, 0, 0, 0}, 1'b0};
      vecs[6] = '{32'h0000_0FFC, 3,   1'b1, -1, 2, '{32'hFFC, 32'h1000, 32'h0, 32'h0}, '{0, 1, 0, 0}, 1'b0};
      vecs[7] = '{32'hFFFF_FFF8, 4,   1'b0, -1, 2, '{32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0}, '{1, 1, 0, 0}, 1'b0};
      vecs[8] = '{32'h0000_0F00, 300, 1'b0, 1,  2, '{32'hF00, 32'h1000, 32'h0, 32'h0}, '{63, 235, 0, 0}, 1'b1};
      post_rst = '{32'h0000_0080, 5, 1'b0, -1, 1, '{32'h80, 32'h0, 32'h0, 32'h0}, '{4, 0, 0, 0}, 1'b0};

      // Reset state with every input trying to provoke a handshake
      s_valid = 1'b1; m_axi_wready = 1'b1; m_axi_awready = 1'b1; m_axi_bvalid = 1'b1;
      start = 1'b1; length = 16'd4;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      chk("reset_awsize", m_axi_awsize, 2);
      start = 1'b0; s_valid = 1'b0; m_axi_wready = 1'b0; m_axi_awready = 1'b0; m_axi_bvalid = 1'b0;
      rst_n = 1'b1;

      // Hand-timed two-beat command with one awready stall
      addr = 32'h40; length = 16'd2;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("t_calc_busy", busy, 1);
      chk("t_calc_awvalid", m_axi_awvalid, 0);
      @(negedge clk);
      chk("t_awvalid", m_axi_awvalid, 1);
      chk("t_awaddr", m_axi_awaddr, 32'h40);
      chk("t_awlen", m_axi_awlen, 1);
      chk("t_awattr", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos},
          {1'b0, 3'd2, 2'b01, 1'b0, 4'd2, 3'd2, 4'd0});
      @(negedge clk);
      chk("t_aw_hold_valid", m_axi_awvalid, 1);
      chk("t_aw_hold_addr", m_axi_awaddr, 32'h40);
      m_axi_awready = 1'b1;
      @(negedge clk);
      m_axi_awready = 1'b0;
      chk("t_aw_dropped", m_axi_awvalid, 0);
      s_valid = 1'b1; s_wdata = 32'h1111_1111; s_wstrb = 4'hF; m_axi_wready = 1'b1;
      #1;
      chk("t_wvalid", m_axi_wvalid, 1);
      chk("t_s_ready", s_ready, 1);
      chk("t_wlast_b0", m_axi_wlast, 0);
      chk("t_wdata_b0", m_axi_wdata, 32'h1111_1111);
      @(negedge clk);
      s_wdata = 32'h2222_2222; s_wstrb = 4'h3;
      #1;
      chk("t_wlast_b1", m_axi_wlast, 1);
      chk("t_wdata_wstrb_b1", {m_axi_wdata, m_axi_wstrb}, {32'h2222_2222, 4'h3});
      @(negedge clk);
      #1;
      chk("t_resp_bready", m_axi_bready, 1);
      chk("t_resp_gated", {m_axi_wvalid, s_ready}, 2'b00);
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
      @(negedge clk);
      m_axi_bvalid = 1'b0; s_valid = 1'b0; m_axi_wready = 1'b0;
      chk("t_done", done, 1);
      chk("t_done_busy", busy, 0);
      chk("t_done_error", error, 0);
      @(negedge clk);
      chk("t_done_pulse_end", done, 0);

      // Table of commands
      for (int v = 0; v < 9; v++) begin
         chk("err_held_until_start", error, (v == 0) ? 1'b0 : vecs[v-1].err);
         run_vec(vecs[v], v);
      end

      // Zero-length command: done next cycle, error cleared, no AXI activity
      chk("zl_err_before", error, 1);
      addr = 32'h100; length = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("zl_done", done, 1);
      chk("zl_busy", busy, 0);
      chk("zl_error", error, 0);
      chk("zl_awvalid", m_axi_awvalid, 0);
      @(negedge clk);
      chk("zl_done_end", done, 0);
      chk("zl_awvalid2", m_axi_awvalid, 0);

      // Reset during the third data beat, then a normal command
      flush();
      tag = 8'hEE; src_len = 16; stall = 1'b0; bad_burst = -1;
      addr = 32'h300; length = 16'd16; manual = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 200 && beat_q.size() < 3; c++) begin
         @(negedge clk);
         #2;
      end
      chk("mr_reached_beat3", beat_q.size() >= 3, 1);
      manual = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(post_rst, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
